// File: rtl/player_array.sv
// Game state machine plus per-player height, gravity and death tracking,
// advanced once per frame tick for NUM_PLAYERS players over NUM_LANES lanes.
module player_array #(
  parameter int NUM_PLAYERS = 4,
  parameter int NUM_LANES   = 3,
  parameter int LANE_PITCH  = 120,
  parameter int STEP        = 4,
  parameter int HEIGHT_W    = 9,
  parameter int SCORE_W     = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             tick,
  input  logic                             start,
  input  logic [NUM_PLAYERS-1:0]           p_en,
  input  logic [NUM_PLAYERS-1:0]           toggle,
  input  logic [NUM_PLAYERS*NUM_LANES-1:0] lines,
  output logic [NUM_PLAYERS*HEIGHT_W-1:0]  height,
  output logic [NUM_PLAYERS-1:0]           grav_dir,
  output logic [NUM_PLAYERS-1:0]           in_play,
  output logic [NUM_PLAYERS-1:0]           dead,
  output logic                             enable_board,
  output logic                             game_over,
  output logic [2:0]                       winner,
  output logic                             winner_valid,
  output logic [SCORE_W-1:0]               score
);

  localparam logic [HEIGHT_W-1:0] MAX_H   = HEIGHT_W'(LANE_PITCH * (NUM_LANES + 1));
  localparam logic [HEIGHT_W-1:0] START_H = HEIGHT_W'(LANE_PITCH * ((NUM_LANES + 1) / 2));
  localparam logic [HEIGHT_W-1:0] STEP_H  = HEIGHT_W'(STEP);

  typedef enum logic [1:0] {IDLE, RUNNING, OVER} state_t;

  state_t                          state, state_next;
  logic                            start_q;
  logic [NUM_PLAYERS-1:0]          toggle_q, pending;
  logic                            start_edge;
  logic [NUM_PLAYERS-1:0]          toggle_edge, alive;
  logic [3:0]                      n_play, n_alive;

  logic [NUM_PLAYERS*HEIGHT_W-1:0] height_next;
  logic [NUM_PLAYERS-1:0]          grav_next, in_play_next, dead_next, pending_next;
  logic [SCORE_W-1:0]              score_next;
  logic [2:0]                      winner_next;
  logic                            winner_valid_next;
  logic [HEIGHT_W-1:0]             h_cur, h_new;
  logic                            supported;

  // A player standing exactly on a present lane surface touches it from
  // either side, so support does not depend on gravity direction.
  function automatic logic on_lane(input logic [HEIGHT_W-1:0] h,
                                   input logic [NUM_LANES-1:0] ln);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_LANES; k++)
      if (ln[k] && h == HEIGHT_W'(LANE_PITCH * (k + 1))) hit = 1'b1;
    return hit;
  endfunction

  function automatic logic [3:0] count_ones(input logic [NUM_PLAYERS-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) n = n + 4'(v[i]);
    return n;
  endfunction

  assign start_edge  = start & ~start_q;
  assign toggle_edge = toggle & ~toggle_q;
  assign alive       = in_play & ~dead;
  assign n_play      = count_ones(in_play);
  assign n_alive     = count_ones(alive);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next        = state;
    height_next       = height;
    grav_next         = grav_dir;
    in_play_next      = in_play;
    dead_next         = dead;
    score_next        = score;
    winner_next       = winner;
    winner_valid_next = winner_valid;
    pending_next      = '0;
    h_cur             = '0;
    h_new             = '0;
    supported         = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge && (|p_en)) begin
          in_play_next = p_en;
          dead_next    = ~p_en;
          grav_next    = '0;
          score_next   = '0;
          for (int i = 0; i < NUM_PLAYERS; i++)
            height_next[i*HEIGHT_W +: HEIGHT_W] = START_H;
          state_next   = RUNNING;
        end
      end
      RUNNING: begin
        if (tick) begin
          for (int i = 0; i < NUM_PLAYERS; i++) begin
            if (alive[i]) begin
              h_cur     = height[i*HEIGHT_W +: HEIGHT_W];
              supported = on_lane(h_cur, lines[i*NUM_LANES +: NUM_LANES]);
              if ((pending[i] || toggle_edge[i]) && supported) begin
                grav_next[i] = ~grav_dir[i];
              end else if (!supported) begin
                if (grav_dir[i]) h_new = (h_cur >= MAX_H - STEP_H) ? MAX_H : h_cur + STEP_H;
                else             h_new = (h_cur <= STEP_H) ? '0 : h_cur - STEP_H;
                height_next[i*HEIGHT_W +: HEIGHT_W] = h_new;
                if (h_new == '0 || h_new == MAX_H) dead_next[i] = 1'b1;
              end
            end
          end
          score_next = (&score) ? score : score + SCORE_W'(1);
        end else begin
          pending_next = pending | toggle_edge;
        end
        // Solo games end only when the lone player dies; otherwise last one standing wins.
        if ((n_play > 4'd1 && n_alive <= 4'd1) || (n_play == 4'd1 && n_alive == 4'd0)) begin
          state_next        = OVER;
          winner_valid_next = (n_alive == 4'd1);
          winner_next       = '0;
          for (int i = 0; i < NUM_PLAYERS; i++)
            if (alive[i]) winner_next = 3'(i);
        end
      end
      OVER: begin
        if (start_edge) begin
          state_next        = IDLE;
          in_play_next      = '0;
          dead_next         = '0;
          winner_next       = '0;
          winner_valid_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q      <= 1'b0;
      toggle_q     <= '0;
      pending      <= '0;
      height       <= {NUM_PLAYERS{START_H}};
      grav_dir     <= '0;
      in_play      <= '0;
      dead         <= '0;
      score        <= '0;
      winner       <= '0;
      winner_valid <= 1'b0;
      enable_board <= 1'b0;
      game_over    <= 1'b0;
    end else begin
      start_q      <= start;
      toggle_q     <= toggle;
      pending      <= pending_next;
      height       <= height_next;
      grav_dir     <= grav_next;
      in_play      <= in_play_next;
      dead         <= dead_next;
      score        <= score_next;
      winner       <= winner_next;
      winner_valid <= winner_valid_next;
      enable_board <= (state_next == RUNNING);
      game_over    <= (state_next == OVER);
    end
  end

endmodule

// File: tb/tb_player_array.sv
// Randomized and directed bench for player_array against a behavioural game model.
module tb_player_array;

  localparam int NP = 4;
  localparam int NL = 3;
  localparam int HW = 9;

  logic              clk, reset, tick, start;
  logic [NP-1:0]     p_en, toggle;
  logic [NP*NL-1:0]  lines;
  logic [NP*HW-1:0]  height;
  logic [NP-1:0]     grav_dir, in_play, dead;
  logic              enable_board, game_over, winner_valid;
  logic [2:0]        winner;
  logic [15:0]       score;

  int total = 0;
  int bad   = 0;

  // Game model: heights as plain integers, state 0=idle 1=running 2=over.
  int mh[NP];
  bit mg[NP], mplay[NP], mdead[NP], mpend[NP];
  int mstate, mscore, mwin;
  bit mwv, mps;
  bit [NP-1:0] mpt;

  player_array dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start), .p_en(p_en),
    .toggle(toggle), .lines(lines), .height(height), .grav_dir(grav_dir),
    .in_play(in_play), .dead(dead), .enable_board(enable_board),
    .game_over(game_over), .winner(winner), .winner_valid(winner_valid),
    .score(score)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NP; i++) begin
      mh[i] = 240; mg[i] = 0; mplay[i] = 0; mdead[i] = 0; mpend[i] = 0;
    end
    mstate = 0; mscore = 0; mwin = 0; mwv = 0; mps = 0; mpt = '0;
  endfunction

  function automatic void model_step();
    int nplay = 0;
    int nalive = 0;
    int who = 0;
    bit sedge;
    bit sup;
    bit [NP-1:0] tedge;
    sedge = start && !mps;
    tedge = toggle & ~mpt;
    for (int i = 0; i < NP; i++) begin
      if (mplay[i]) nplay++;
      if (mplay[i] && !mdead[i]) begin nalive++; who = i; end
    end
    case (mstate)
      0: begin
        for (int i = 0; i < NP; i++) mpend[i] = 0;
        if (sedge && p_en != 0) begin
          for (int i = 0; i < NP; i++) begin
            mplay[i] = p_en[i]; mdead[i] = !p_en[i]; mh[i] = 240; mg[i] = 0;
          end
          mscore = 0;
          mstate = 1;
        end
      end
      1: begin
        if (tick) begin
          for (int i = 0; i < NP; i++) begin
            if (mplay[i] && !mdead[i]) begin
              sup = 0;
              for (int k = 0; k < NL; k++)
                if (lines[i*NL+k] && mh[i] == 120 * (k + 1)) sup = 1;
              if ((mpend[i] || tedge[i]) && sup) mg[i] = !mg[i];
              else if (!sup) begin
                mh[i] = mh[i] + (mg[i] ? 4 : -4);
                if (mh[i] <= 0) begin mh[i] = 0; mdead[i] = 1; end
                else if (mh[i] >= 480) begin mh[i] = 480; mdead[i] = 1; end
              end
            end
            mpend[i] = 0;
          end
          if (mscore < 65535) mscore++;
        end else begin
          for (int i = 0; i < NP; i++) mpend[i] = mpend[i] | tedge[i];
        end
        if ((nplay > 1 && nalive <= 1) || (nplay == 1 && nalive == 0)) begin
          mstate = 2;
          mwv = (nalive == 1);
          mwin = mwv ? who : 0;
        end
      end
      default: begin
        for (int i = 0; i < NP; i++) mpend[i] = 0;
        if (sedge) begin
          mstate = 0;
          for (int i = 0; i < NP; i++) begin mplay[i] = 0; mdead[i] = 0; end
          mwin = 0; mwv = 0;
        end
      end
    endcase
    mps = start;
    mpt = toggle;
  endfunction

  task automatic compare_all();
    logic [NP*HW-1:0] eh;
    logic [NP-1:0] eg, ep, ed;
    for (int i = 0; i < NP; i++) begin
      eh[i*HW +: HW] = HW'(mh[i]);
      eg[i] = mg[i]; ep[i] = mplay[i]; ed[i] = mdead[i];
    end
    check("height", height, eh);
    check("grav_dir", grav_dir, eg);
    check("in_play", in_play, ep);
    check("dead", dead, ed);
    check("enable_board", enable_board, mstate == 1);
    check("game_over", game_over, mstate == 2);
    check("winner", winner, 3'(mwin));
    check("winner_valid", winner_valid, mwv);
    check("score", score, 16'(mscore));
  endtask

  // One clock: inputs applied at the falling edge, outputs checked 1 after the rise.
  task automatic step(input logic t, input logic s, input logic [NP-1:0] pe,
                      input logic [NP-1:0] tg, input logic [NP*NL-1:0] ln);
    tick = t; start = s; p_en = pe; toggle = tg; lines = ln;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic press_start(input logic [NP-1:0] pe);
    step(1'b0, 1'b1, pe, '0, '0);
    step(1'b0, 1'b0, pe, '0, '0);
  endtask

  initial begin
    reset = 1'b0; tick = 0; start = 0; p_en = '0; toggle = '0; lines = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    check("rst_h0", height[HW-1:0], 9'd240);
    check("rst_score", score, 16'd0);
    @(negedge clk);
    reset = 1'b1;

    // Lock-in, then everyone falls with no lanes: both die on tick 60, draw.
    step(1'b0, 1'b1, 4'b0101, '0, '0);
    check("lock_in_play", in_play, 4'b0101);
    check("lock_dead", dead, 4'b1010);
    check("lock_enable", enable_board, 1'b1);
    step(1'b0, 1'b0, 4'b0101, '0, '0);
    step(1'b1, 1'b0, 4'b0101, '0, '0);
    check("fall_first", height[HW-1:0], 9'd236);
    repeat (59) step(1'b1, 1'b0, 4'b0101, '0, '0);
    check("fall_floor", height[HW-1:0], 9'd0);
    check("fall_dead", dead, 4'b1111);
    check("fall_not_over_yet", game_over, 1'b0);
    step(1'b0, 1'b0, 4'b0101, '0, '0);
    check("draw_over", game_over, 1'b1);
    check("draw_valid", winner_valid, 1'b0);

    // Solo: supported flips, rest on a lane, airborne toggle discarded.
    press_start('0);
    press_start(4'b0001);
    step(1'b0, 1'b0, 4'b0001, 4'b0001, '1);
    step(1'b1, 1'b0, 4'b0001, 4'b0000, '1);
    check("flip_dir", grav_dir[0], 1'b1);
    check("flip_h", height[HW-1:0], 9'd240);
    step(1'b1, 1'b0, 4'b0001, 4'b0000, '1);
    check("ceiling_rest", height[HW-1:0], 9'd240);
    step(1'b1, 1'b0, 4'b0001, 4'b0001, '1);
    check("same_cycle_flip", grav_dir[0], 1'b0);
    step(1'b1, 1'b0, 4'b0001, 4'b0000, '0);
    check("air_h", height[HW-1:0], 9'd236);
    step(1'b0, 1'b0, 4'b0001, 4'b0001, '0);
    step(1'b1, 1'b0, 4'b0001, 4'b0000, '0);
    check("air_dir_kept", grav_dir[0], 1'b0);
    check("air_h2", height[HW-1:0], 9'd232);
    repeat (30) step(1'b1, 1'b0, 4'b0001, 4'b0000, '1);
    check("land_lane0", height[HW-1:0], 9'd120);
    repeat (30) step(1'b1, 1'b0, 4'b0001, 4'b0000, '0);
    check("solo_dead", dead[0], 1'b1);
    step(1'b0, 1'b0, 4'b0001, 4'b0000, '0);
    check("solo_over", game_over, 1'b1);
    check("solo_valid", winner_valid, 1'b0);

    // Three players: 0 and 2 fall, 1 stands on its lane and wins.
    press_start('0);
    press_start(4'b0111);
    repeat (60) step(1'b1, 1'b0, 4'b0111, '0, 12'b000_000_111_000);
    step(1'b0, 1'b0, 4'b0111, '0, 12'b000_000_111_000);
    check("win_over", game_over, 1'b1);
    check("win_idx", winner, 3'd1);
    check("win_valid", winner_valid, 1'b1);
    check("win_h1", height[HW +: HW], 9'd240);

    // Asynchronous reset in the middle of a running game.
    press_start('0);
    press_start(4'b1111);
    repeat (5) step(1'b1, 1'b0, 4'b1111, '0, 12'($urandom));
    #2 reset = 1'b0;
    #1 model_reset();
    compare_all();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    check("arst_score", score, 16'd0);
    check("arst_enable", enable_board, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Random play.
    for (int n = 0; n < 8000; n++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
           4'($urandom), 4'($urandom), 12'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/player_array.md
# player_array

Parametrised successor to the fixed four-player start/gravity/move/dead chain in `top`. It owns the game state machine and every player's position, gravity direction and death status for `NUM_PLAYERS` players over `NUM_LANES` lines, all advanced once per frame tick. It sits between the debouncers/line generators (inputs) and the renderer (outputs), and replaces `start_game`, `dead`, `gavity_direction` and `move_player`.

## Interface
- `NUM_PLAYERS`, 4: number of player slots, 1..8.
- `NUM_LANES`, 3: number of horizontal lines; lane k (0 = bottom) has surface height `LANE_PITCH*(k+1)`.
- `LANE_PITCH`, 120: vertical distance between lanes; must be a multiple of `STEP`.
- `STEP`, 4: height change per tick while a player is airborne.
- `HEIGHT_W`, 9: height width; `MAX_H = LANE_PITCH*(NUM_LANES+1)` must fit in it.
- `SCORE_W`, 16: width of the frame counter.

Ports (clock and reset first):
- `clk` in 1: system clock. One clock; all state in this domain.
- `reset` in 1: asynchronous, active-low; while low, all state returns to its reset values.
- `tick` in 1: single-cycle frame enable (60 Hz strobe, synchronous to `clk`).
- `start` in 1: debounced start button (level).
- `p_en` in `NUM_PLAYERS`: player enable switches, sampled only in IDLE.
- `toggle` in `NUM_PLAYERS`: debounced gravity buttons (level); bit i belongs to player i.
- `lines` in `NUM_PLAYERS*NUM_LANES`: bits [i*NUM_LANES+k] = lane k present at player i's x position.
- `height` out `NUM_PLAYERS*HEIGHT_W`: packed heights; player i occupies bits [i*HEIGHT_W +: HEIGHT_W].
- `grav_dir` out `NUM_PLAYERS`: 0 = gravity down (height decreasing), 1 = up.
- `in_play` out `NUM_PLAYERS`: players locked in at start.
- `dead` out `NUM_PLAYERS`: player out of the game.
- `enable_board` out 1: high in RUNNING only.
- `game_over` out 1: high in OVER only.
- `winner` out 3: index of the surviving player; valid when `winner_valid` = 1.
- `winner_valid` out 1.
- `score` out `SCORE_W`: ticks elapsed in RUNNING; saturates at all-ones.

## Operation
- **Reset values:** state IDLE; `height` = `START_H` for every player, where `START_H = LANE_PITCH*((NUM_LANES+1)/2)` (240 with the defaults); `grav_dir` = 0; `in_play`, `dead`, `enable_board`, `game_over`, `winner`, `winner_valid`, `score` all 0; edge registers and pending flags cleared.
- **Edge detection:** rising edges of `start` and of each `toggle` bit are detected against the previous-cycle value.
- **IDLE:**
  - On a `start` edge with `p_en` != 0: `in_play` <= `p_en`; heights <= `START_H`; `grav_dir` <= 0; `dead` <= ~`p_en`; `score` <= 0; go to RUNNING.
  - A `start` edge with `p_en` == 0 is ignored.
- **RUNNING:**
  - A `toggle` edge sets pending[i]. Pending flags are cleared on every `tick`.
  - On `tick`, for each live player i:
    - Supported = height is a lane surface `LANE_PITCH*(k+1)` and lane k is present, checking direction-consistently: the lane is below when `grav_dir` = 0, and it counts as the ceiling lane when `grav_dir` = 1. A player exactly on a lane is treated as touching it from either side.
    - If pending[i] and supported: `grav_dir` flips and height is unchanged this tick.
    - Else if not supported: height moves `STEP` in the gravity direction.
    - A pending flag on an unsupported player is discarded.
    - If the new height is 0 or `MAX_H`, `dead[i]` <= 1 on the same edge; height saturates at that bound.
  - Dead or non-playing players hold height and `grav_dir`.
  - `score` increments on each `tick`.
  - Alive count is evaluated every cycle from registered `dead`/`in_play`:
    - more than one player enabled: go to OVER when alive count <= 1;
    - exactly one player enabled: go to OVER when alive count == 0.
- **OVER:**
  - On entry: `winner_valid` = 1 and `winner` = index of the sole live player if there is exactly one; otherwise `winner_valid` = 0 (draw or single-player loss).
  - Heights, `dead` and `score` are frozen.
  - A `start` edge returns to IDLE and clears `in_play`, `dead` and the winner outputs.
- **Reset mid-operation:** asynchronous return to the reset values from any state.

## Timing
- All outputs are registered.
- Height, `grav_dir` and `dead` update on the edge at which `tick` is sampled high.
- `game_over` and the winner outputs assert one `clk` after the `dead` change that triggers them.
- `enable_board` rises one `clk` after the `start` edge is sampled.
- A `toggle` edge and a `tick` in the same cycle: the toggle applies on that tick.
- A `start` edge in RUNNING is ignored.

## Test plan
- **Lock-in:** `p_en`=4'b0101, `start` pulse -> `in_play`=0101, `dead`=1010, heights 240, `enable_board`=1 one cycle later.
- **Fall to floor with no lanes:** `lines`=0 -> player height falls 4 per tick; after 60 ticks height=0, `dead`=1 on that edge; OVER follows per the alive-count rule.
- **Supported flip:** all lanes present, player on the 240 lane, `toggle` edge then `tick` -> `grav_dir`=1 with height still 240; next tick the player rests at 240, since lane 1 is treated as touched from either side.
- **Airborne toggle discarded:** `toggle` edge while falling -> `grav_dir` unchanged and pending flag cleared at the tick.
- **Winner:** 3 players; kill players 0 and 2 via `lines`=0 while player 1 stands on a lane -> `game_over`=1, `winner`=1, `winner_valid`=1; two players dying on the same tick -> `winner_valid`=0.
- **Async reset mid-RUNNING:** `reset` low for 3 cycles -> IDLE, all outputs at their reset values, `score`=0.
